// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types and default sizing for the execute-stage writeback arbiter.
package fu_wb_arbiter_pkg;

  localparam int unsigned TRANS_ID_BITS  = 3;
  localparam int unsigned NR_FU_CHANNELS = 4;
  localparam int unsigned NR_WB_PORTS    = 2;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]              result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    exception_t               ex;
  } fu_wb_t;

endpackage

// File: rtl/fu_wb_arbiter_chan_buf.sv
// Per-channel result FIFO with a zero-latency bypass head when empty.
module wb_chan_buf
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned Depth     = 2,
  parameter int unsigned DataWidth = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DataWidth-1:0]     in_result,
  input  logic [TRANS_ID_BITS-1:0] in_trans_id,
  input  exception_t               in_ex,
  input  logic                     grant,
  output logic                     cand,
  output logic [DataWidth-1:0]     head_result,
  output logic [TRANS_ID_BITS-1:0] head_trans_id,
  output exception_t               head_ex
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0]     mem_result   [Depth];
  logic [TRANS_ID_BITS-1:0] mem_trans_id [Depth];
  exception_t               mem_ex       [Depth];

  logic [PtrW-1:0] rd_ptr, wr_ptr;
  logic [CntW-1:0] count;
  logic            empty, accept, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = (count != CntW'(Depth));
  assign empty    = (count == '0);
  assign accept   = in_valid && in_ready;
  assign cand     = !empty || accept;
  // A granted handshake into an empty buffer bypasses storage entirely.
  assign push     = accept && !(empty && grant);
  assign pop      = grant && !empty;

  assign head_result   = empty ? in_result   : mem_result[rd_ptr];
  assign head_trans_id = empty ? in_trans_id : mem_trans_id[rd_ptr];
  assign head_ex       = empty ? in_ex       : mem_ex[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_result[wr_ptr]   <= in_result;
      mem_trans_id[wr_ptr] <= in_trans_id;
      mem_ex[wr_ptr]       <= in_ex;
    end
  end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Round-robin writeback arbiter: NrChannels buffered FU result channels
// onto NrWbPorts scoreboard writeback ports.
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned NrChannels = NR_FU_CHANNELS,
  parameter int unsigned NrWbPorts  = NR_WB_PORTS,
  parameter int unsigned Depth      = 2,
  parameter int unsigned DataWidth  = 64
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      flush_i,
  input  logic [NrChannels-1:0]                     fu_valid_i,
  output logic [NrChannels-1:0]                     fu_ready_o,
  input  logic [NrChannels-1:0][DataWidth-1:0]      fu_result_i,
  input  logic [NrChannels-1:0][TRANS_ID_BITS-1:0]  fu_trans_id_i,
  input  exception_t [NrChannels-1:0]               fu_exception_i,
  output logic [NrWbPorts-1:0]                      wb_valid_o,
  output logic [NrWbPorts-1:0][DataWidth-1:0]       wb_result_o,
  output logic [NrWbPorts-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output exception_t [NrWbPorts-1:0]                wb_exception_o,
  output logic                                      wb_stall_o
);

  localparam int unsigned RrW   = $clog2(NrChannels);
  localparam int unsigned CandW = $clog2(NrChannels + 1);

  if (NrWbPorts < 1 || NrWbPorts > NrChannels) begin : g_bad_ports
    $error("fu_wb_arbiter: NrWbPorts must be within 1..NrChannels");
  end
  if (Depth < 1) begin : g_bad_depth
    $error("fu_wb_arbiter: Depth must be at least 1");
  end

  logic [NrChannels-1:0]    cand, grant;
  logic [DataWidth-1:0]     head_result   [NrChannels];
  logic [TRANS_ID_BITS-1:0] head_trans_id [NrChannels];
  exception_t               head_ex       [NrChannels];
  logic [RrW-1:0]           rr_ptr, rr_next;
  logic [CandW-1:0]         n_cand;
  logic                     active;
  logic                     dup_id;

  for (genvar c = 0; c < NrChannels; c++) begin : g_chan
    wb_chan_buf #(
      .Depth     (Depth),
      .DataWidth (DataWidth)
    ) u_buf (
      .clk           (clk_i),
      .rst_n         (rst_ni),
      .flush         (flush_i),
      .in_valid      (fu_valid_i[c]),
      .in_ready      (fu_ready_o[c]),
      .in_result     (fu_result_i[c]),
      .in_trans_id   (fu_trans_id_i[c]),
      .in_ex         (fu_exception_i[c]),
      .grant         (grant[c]),
      .cand          (cand[c]),
      .head_result   (head_result[c]),
      .head_trans_id (head_trans_id[c]),
      .head_ex       (head_ex[c])
    );
  end

  // Gating on rst_ni keeps the bypass path quiet while reset is held.
  assign active = rst_ni && !flush_i;

  always_comb begin
    int unsigned idx;
    int unsigned nport;
    grant          = '0;
    wb_valid_o     = '0;
    wb_result_o    = '0;
    wb_trans_id_o  = '0;
    wb_exception_o = '0;
    n_cand         = '0;
    rr_next        = rr_ptr;
    nport          = 0;
    for (int unsigned i = 0; i < NrChannels; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NrChannels) idx = idx - NrChannels;
      if (active && cand[idx]) begin
        n_cand = n_cand + 1'b1;
        if (nport < NrWbPorts) begin
          grant[idx]            = 1'b1;
          wb_valid_o[nport]     = 1'b1;
          wb_result_o[nport]    = head_result[idx];
          wb_trans_id_o[nport]  = head_trans_id[idx];
          wb_exception_o[nport] = head_ex[idx];
          rr_next = (idx == NrChannels - 1) ? '0 : RrW'(idx + 1);
          nport   = nport + 1;
        end
      end
    end
  end

  assign wb_stall_o = (n_cand > CandW'(NrWbPorts));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rr_ptr <= '0;
    else if (flush_i) rr_ptr <= '0;
    else              rr_ptr <= rr_next;
  end

  always_comb begin
    dup_id = 1'b0;
    for (int unsigned i = 0; i < NrWbPorts; i++) begin
      for (int unsigned j = i + 1; j < NrWbPorts; j++) begin
        if (wb_valid_o[i] && wb_valid_o[j] && (wb_trans_id_o[i] == wb_trans_id_o[j])) dup_id = 1'b1;
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !dup_id);

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed and random scenarios for the writeback arbiter (2-port and 1-port instances).
module tb_fu_wb_arbiter;
  import fu_wb_arbiter_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 64;

  typedef struct packed {
    logic [2:0]  id;
    logic [63:0] data;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [NCH-1:0]          fu_valid = '0;
  logic [NCH-1:0][DW-1:0]  fu_result = '0;
  logic [NCH-1:0][2:0]     fu_trans_id = '0;
  exception_t [NCH-1:0]    fu_ex = '0;

  logic [NCH-1:0]          fu_ready0, fu_ready1;
  logic [1:0]              wb_valid0;
  logic [1:0][DW-1:0]      wb_result0;
  logic [1:0][2:0]         wb_trans_id0;
  exception_t [1:0]        wb_ex0;
  logic                    stall0;
  logic [0:0]              wb_valid1;
  logic [0:0][DW-1:0]      wb_result1;
  logic [0:0][2:0]         wb_trans_id1;
  exception_t [0:0]        wb_ex1;
  logic                    stall1;

  int checks = 0;
  int errors = 0;
  item_t sb_q [NCH][$];

  always #5 clk = ~clk;

  fu_wb_arbiter #(.NrChannels(4), .NrWbPorts(2), .Depth(2), .DataWidth(64)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .fu_valid_i(fu_valid), .fu_ready_o(fu_ready0), .fu_result_i(fu_result),
    .fu_trans_id_i(fu_trans_id), .fu_exception_i(fu_ex),
    .wb_valid_o(wb_valid0), .wb_result_o(wb_result0), .wb_trans_id_o(wb_trans_id0),
    .wb_exception_o(wb_ex0), .wb_stall_o(stall0)
  );

  fu_wb_arbiter #(.NrChannels(4), .NrWbPorts(1), .Depth(2), .DataWidth(64)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .fu_valid_i(fu_valid), .fu_ready_o(fu_ready1), .fu_result_i(fu_result),
    .fu_trans_id_i(fu_trans_id), .fu_exception_i(fu_ex),
    .wb_valid_o(wb_valid1), .wb_result_o(wb_result1), .wb_trans_id_o(wb_trans_id1),
    .wb_exception_o(wb_ex1), .wb_stall_o(stall1)
  );

  function automatic exception_t mk_ex(input logic [63:0] d, input logic [2:0] id);
    return '{cause: d ^ 64'hFF, tval: d, valid: id[0]};
  endfunction

  task automatic set_ch(input int c, input logic [2:0] id, input logic [63:0] data);
    fu_valid[c]    = 1'b1;
    fu_trans_id[c] = id;
    fu_result[c]   = data;
    fu_ex[c]       = mk_ex(data, id);
  endtask

  task automatic clear_inputs();
    fu_valid = '0; fu_result = '0; fu_trans_id = '0; fu_ex = '0; flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #3;
    checks++; if (fu_ready0 !== 4'hF) begin errors++; $display("FAIL rst_ready0 got %h exp %h", fu_ready0, 4'hF); end
    checks++; if (fu_ready1 !== 4'hF) begin errors++; $display("FAIL rst_ready1 got %h exp %h", fu_ready1, 4'hF); end
    checks++; if (wb_valid0 !== 2'b00) begin errors++; $display("FAIL rst_valid got %b exp 00", wb_valid0); end
    checks++; if (wb_result0 !== '0) begin errors++; $display("FAIL rst_result got %h exp 0", wb_result0); end
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall0); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_ch(1, 3'd3, 64'hA5);
    @(negedge clk);
    checks++; if (wb_valid0 !== 2'b01) begin errors++; $display("FAIL t1_valid got %b exp 01", wb_valid0); end
    checks++; if (wb_trans_id0[0] !== 3'd3) begin errors++; $display("FAIL t1_id got %0d exp 3", wb_trans_id0[0]); end
    checks++; if (wb_result0[0] !== 64'hA5) begin errors++; $display("FAIL t1_data got %h exp a5", wb_result0[0]); end
    checks++; if (wb_ex0[0] !== mk_ex(64'hA5, 3'd3)) begin errors++; $display("FAIL t1_ex got %h", wb_ex0[0]); end
    checks++; if (fu_ready0 !== 4'hF) begin errors++; $display("FAIL t1_ready got %h exp f", fu_ready0); end
    checks++; if (wb_result0[1] !== '0 || wb_trans_id0[1] !== '0) begin errors++; $display("FAIL t1_unused_port got %h/%0d exp 0", wb_result0[1], wb_trans_id0[1]); end
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL t1_stall got %b exp 0", stall0); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (wb_valid0 !== 2'b00) begin errors++; $display("FAIL t1_after got %b exp 00", wb_valid0); end
    next_cycle();
  endtask

  task automatic test_all_four();
    set_ch(3, 3'd7, 64'h33);
    @(negedge clk);
    checks++; if (wb_valid0 !== 2'b01 || wb_trans_id0[0] !== 3'd7) begin errors++; $display("FAIL t2_pre got %b/%0d exp 01/7", wb_valid0, wb_trans_id0[0]); end
    next_cycle();
    clear_inputs();
    for (int c = 0; c < NCH; c++) set_ch(c, 3'(c), 64'h100 + 64'(c));
    @(negedge clk);
    checks++; if (wb_valid0 !== 2'b11) begin errors++; $display("FAIL t2_c0_valid got %b exp 11", wb_valid0); end
    checks++; if (wb_trans_id0[0] !== 3'd0 || wb_trans_id0[1] !== 3'd1) begin errors++; $display("FAIL t2_c0_ids got %0d,%0d exp 0,1", wb_trans_id0[0], wb_trans_id0[1]); end
    checks++; if (wb_result0[1] !== 64'h101) begin errors++; $display("FAIL t2_c0_data got %h exp 101", wb_result0[1]); end
    checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL t2_c0_stall got %b exp 1", stall0); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (wb_valid0 !== 2'b11) begin errors++; $display("FAIL t2_c1_valid got %b exp 11", wb_valid0); end
    checks++; if (wb_trans_id0[0] !== 3'd2 || wb_trans_id0[1] !== 3'd3) begin errors++; $display("FAIL t2_c1_ids got %0d,%0d exp 2,3", wb_trans_id0[0], wb_trans_id0[1]); end
    checks++; if (wb_result0[0] !== 64'h102 || wb_result0[1] !== 64'h103) begin errors++; $display("FAIL t2_c1_data got %h,%h exp 102,103", wb_result0[0], wb_result0[1]); end
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL t2_c1_stall got %b exp 0", stall0); end
    next_cycle();
    @(negedge clk);
    checks++; if (wb_valid0 !== 2'b00) begin errors++; $display("FAIL t2_c2_valid got %b exp 00", wb_valid0); end
    next_cycle();
    // rr_ptr must be back at 0: channel 0 wins port 0 over channel 3
    set_ch(0, 3'd0, 64'h200);
    set_ch(3, 3'd6, 64'h206);
    @(negedge clk);
    checks++; if (wb_trans_id0[0] !== 3'd0 || wb_trans_id0[1] !== 3'd6) begin errors++; $display("FAIL t2_rr got %0d,%0d exp 0,6", wb_trans_id0[0], wb_trans_id0[1]); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_starve();
    int seq [NCH];
    logic [1:0] cc;
    apply_reset();
    set_ch(0, 3'd0, 64'h55);
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b1 || wb_trans_id1[0] !== 3'd0) begin errors++; $display("FAIL t3_pre got %b/%0d exp 1/0", wb_valid1, wb_trans_id1[0]); end
    next_cycle();
    clear_inputs();
    for (int c = 0; c < NCH; c++) seq[c] = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        cc = c[1:0];
        set_ch(c, {cc, seq[c][0]}, 64'hC000 + 64'(c * 16 + seq[c]));
      end
      @(negedge clk);
      if (cyc == 2) begin
        checks++; if (fu_ready1[0] !== 1'b0) begin errors++; $display("FAIL t3_full got %b exp 0", fu_ready1[0]); end
      end
      if (cyc == 3) begin
        checks++; if (wb_valid1 !== 1'b1 || wb_trans_id1[0] !== 3'd0 || wb_result1[0] !== 64'hC000) begin
          errors++; $display("FAIL t3_grant got %b/%0d/%h exp 1/0/c000", wb_valid1, wb_trans_id1[0], wb_result1[0]);
        end
      end
      if (cyc == 4) begin
        checks++; if (fu_ready1[0] !== 1'b1) begin errors++; $display("FAIL t3_ready_rise got %b exp 1", fu_ready1[0]); end
      end
      for (int c = 0; c < NCH; c++) if (fu_ready1[c]) seq[c]++;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    apply_reset();
    set_ch(0, 3'd0, 64'h10);
    set_ch(2, 3'd4, 64'h24);
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b1 || wb_trans_id1[0] !== 3'd0) begin errors++; $display("FAIL t4_c0 got %b/%0d exp 1/0", wb_valid1, wb_trans_id1[0]); end
    next_cycle();
    clear_inputs();
    set_ch(1, 3'd2, 64'h12);
    set_ch(2, 3'd5, 64'h25);
    @(negedge clk);
    checks++; if (wb_trans_id1[0] !== 3'd2 || fu_ready1 !== 4'hF) begin errors++; $display("FAIL t4_c1 got %0d/%h exp 2/f", wb_trans_id1[0], fu_ready1); end
    next_cycle();
    clear_inputs();
    set_ch(2, 3'd4, 64'h2F);
    flush = 1'b1;
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b0 || wb_valid0 !== 2'b00) begin errors++; $display("FAIL t4_flush_valid got %b/%b exp 0/00", wb_valid1, wb_valid0); end
    checks++; if (fu_ready1[2] !== 1'b0) begin errors++; $display("FAIL t4_flush_ready got %b exp 0", fu_ready1[2]); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (fu_ready1 !== 4'hF || fu_ready0 !== 4'hF) begin errors++; $display("FAIL t4_post_ready got %h/%h exp f/f", fu_ready1, fu_ready0); end
    checks++; if (wb_valid1 !== 1'b0 || wb_valid0 !== 2'b00) begin errors++; $display("FAIL t4_post_valid got %b/%b exp 0/00", wb_valid1, wb_valid0); end
    next_cycle();
    set_ch(1, 3'd2, 64'h31);
    set_ch(3, 3'd6, 64'h33);
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b1 || wb_trans_id1[0] !== 3'd2) begin errors++; $display("FAIL t4_rr got %b/%0d exp 1/2", wb_valid1, wb_trans_id1[0]); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b1 || wb_trans_id1[0] !== 3'd6 || wb_result1[0] !== 64'h33) begin errors++; $display("FAIL t4_drain got %b/%0d/%h exp 1/6/33", wb_valid1, wb_trans_id1[0], wb_result1[0]); end
    next_cycle();
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b0) begin errors++; $display("FAIL t4_idle got %b exp 0", wb_valid1); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_ch(0, 3'd0, 64'h40);
    set_ch(1, 3'd2, 64'h41);
    @(negedge clk);
    checks++; if (wb_valid1 !== 1'b1 || wb_trans_id1[0] !== 3'd0) begin errors++; $display("FAIL t5_c0 got %b/%0d exp 1/0", wb_valid1, wb_trans_id1[0]); end
    next_cycle();
    clear_inputs();
    #2;
    checks++; if (wb_valid1 !== 1'b1 || wb_trans_id1[0] !== 3'd2) begin errors++; $display("FAIL t5_buffered got %b/%0d exp 1/2", wb_valid1, wb_trans_id1[0]); end
    rst_n = 1'b0;
    set_ch(2, 3'd4, 64'h42);
    #1;
    checks++; if (wb_valid1 !== 1'b0 || wb_valid0 !== 2'b00) begin errors++; $display("FAIL t5_rst_valid got %b/%b exp 0/00", wb_valid1, wb_valid0); end
    checks++; if (wb_trans_id1[0] !== 3'd0 || wb_result1[0] !== '0 || wb_ex1[0] !== '0) begin errors++; $display("FAIL t5_rst_data got %0d/%h exp 0/0", wb_trans_id1[0], wb_result1[0]); end
    checks++; if (fu_ready1 !== 4'hF || stall1 !== 1'b0) begin errors++; $display("FAIL t5_rst_ready got %h/%b exp f/0", fu_ready1, stall1); end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (wb_valid1 !== 1'b0 || wb_valid0 !== 2'b00) begin errors++; $display("FAIL t5_stale got %b/%b exp 0/00", wb_valid1, wb_valid0); end
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic [NCH-1:0] pend;
    int seq [NCH];
    int unsigned ch;
    item_t exp_it;
    apply_reset();
    pend = '0;
    for (int c = 0; c < NCH; c++) seq[c] = 0;
    for (int cyc = 0; cyc < 10012; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!pend[c]) begin
          if (cyc < 10000 && $urandom_range(0, 99) < 60) begin
            seq[c]++;
            set_ch(c, {c[1:0], seq[c][0]}, {$urandom, $urandom});
          end else begin
            fu_valid[c] = 1'b0;
          end
        end
      end
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (fu_valid[c] && fu_ready0[c]) begin
          sb_q[c].push_back('{id: fu_trans_id[c], data: fu_result[c]});
          pend[c] = 1'b0;
        end else begin
          pend[c] = fu_valid[c];
        end
      end
      checks++; if (wb_valid0 === 2'b10) begin errors++; $display("FAIL rnd_port_fill got %b exp port0 first", wb_valid0); end
      for (int p = 0; p < 2; p++) begin
        if (wb_valid0[p]) begin
          ch = 32'(wb_trans_id0[p][2:1]);
          checks++;
          if (sb_q[ch].size() == 0) begin
            errors++; $display("FAIL rnd_unexpected port %0d got id %0d exp none", p, wb_trans_id0[p]);
          end else begin
            exp_it = sb_q[ch].pop_front();
            if (wb_trans_id0[p] !== exp_it.id || wb_result0[p] !== exp_it.data || wb_ex0[p] !== mk_ex(exp_it.data, exp_it.id)) begin
              errors++; $display("FAIL rnd_wb port %0d got %0d/%h exp %0d/%h", p, wb_trans_id0[p], wb_result0[p], exp_it.id, exp_it.data);
            end
          end
        end
      end
      next_cycle();
    end
    for (int c = 0; c < NCH; c++) begin
      checks++; if (sb_q[c].size() != 0) begin errors++; $display("FAIL rnd_lost ch %0d got %0d pending exp 0", c, sb_q[c].size()); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_starve();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
